// File: rtl/hex_score_display.sv
// hex_score_display
//
// Converts three game status values (ship health, current score, all-time high
// score) from binary to decimal and drives eight active-low seven-segment digits.
// A free-running round-robin FSM converts one field at a time with a sequential
// shift-and-add-3 (double-dabble) pass: 1 LOAD + 8 SHIFT + 1 WRITE cycles per
// field, 30 cycles per full frame.
//
// Ports:
//   clk                in   system clock
//   resetn             in   synchronous reset, active-high (resetn=1 resets)
//   ship_health        in   [3:0] health value, 0-15
//   current_highscore  in   [7:0] current score, 0-255
//   alltime_highscore  in   [7:0] all-time score, 0-255
//   hex0 .. hex7       out  [6:0] active-low segments, bit0=a .. bit6=g
//                           hex1:hex0 = health, hex4..hex2 = current,
//                           hex7..hex5 = all-time
//   frame_done         out  one-cycle pulse when the all-time digits update

module hex_score_display (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] ship_health,
    input  logic [7:0] current_highscore,
    input  logic [7:0] alltime_highscore,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic [6:0] hex6,
    output logic [6:0] hex7,
    output logic       frame_done
);

    localparam logic [1:0] StLoad  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;

    localparam logic [6:0] SegBlank = 7'h7F;

    logic [1:0]  state_q;
    logic [1:0]  fidx_q;
    logic [2:0]  cnt_q;
    // {hundreds[19:16], tens[15:12], units[11:8], binary[7:0]}
    logic [19:0] sreg_q;

    logic [7:0]  load_val;
    logic [19:0] adj;
    logic [19:0] shifted;
    logic [3:0]  bcd_h;
    logic [3:0]  bcd_t;
    logic [3:0]  bcd_u;
    logic [6:0]  seg_h;
    logic [6:0]  seg_t;
    logic [6:0]  seg_u;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SegBlank;
        endcase
    endfunction

    // Field selection for LOAD, zero-extended to 8 bits.
    always_comb begin
        case (fidx_q)
            2'd0:    load_val = {4'h0, ship_health};
            2'd1:    load_val = current_highscore;
            default: load_val = alltime_highscore;
        endcase
    end

    // One double-dabble step: correct each BCD nibble >= 5, then shift left.
    always_comb begin
        adj = sreg_q;
        if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
        if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
        if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
        shifted = {adj[18:0], 1'b0};
    end

    // Digit encoding with leading-zero blanking; units always shown.
    always_comb begin
        bcd_h = sreg_q[19:16];
        bcd_t = sreg_q[15:12];
        bcd_u = sreg_q[11:8];
        seg_h = (bcd_h == 4'd0) ? SegBlank : seg7(bcd_h);
        seg_t = ((bcd_h == 4'd0) && (bcd_t == 4'd0)) ? SegBlank : seg7(bcd_t);
        seg_u = seg7(bcd_u);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q    <= StLoad;
            fidx_q     <= 2'd0;
            cnt_q      <= 3'd0;
            sreg_q     <= 20'd0;
            hex0       <= SegBlank;
            hex1       <= SegBlank;
            hex2       <= SegBlank;
            hex3       <= SegBlank;
            hex4       <= SegBlank;
            hex5       <= SegBlank;
            hex6       <= SegBlank;
            hex7       <= SegBlank;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                StLoad: begin
                    sreg_q  <= {12'h000, load_val};
                    cnt_q   <= 3'd0;
                    state_q <= StShift;
                end
                StShift: begin
                    sreg_q <= shifted;
                    cnt_q  <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_q <= StWrite;
                end
                StWrite: begin
                    case (fidx_q)
                        2'd0: begin
                            // Health hundreds nibble is always zero; dropped.
                            hex1 <= seg_t;
                            hex0 <= seg_u;
                        end
                        2'd1: begin
                            hex4 <= seg_h;
                            hex3 <= seg_t;
                            hex2 <= seg_u;
                        end
                        default: begin
                            hex7       <= seg_h;
                            hex6       <= seg_t;
                            hex5       <= seg_u;
                            frame_done <= 1'b1;
                        end
                    endcase
                    fidx_q  <= (fidx_q == 2'd2) ? 2'd0 : fidx_q + 2'd1;
                    state_q <= StLoad;
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_score_display.sv
module tb_hex_score_display;

    logic       clk;
    logic       resetn;
    logic [3:0] ship_health;
    logic [7:0] current_highscore;
    logic [7:0] alltime_highscore;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic       frame_done;

    logic [55:0] all_hex;
    assign all_hex = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [55:0] AllBlank = {8{7'h7F}};

    hex_score_display dut (
        .clk               (clk),
        .resetn            (resetn),
        .ship_health       (ship_health),
        .current_highscore (current_highscore),
        .alltime_highscore (alltime_highscore),
        .hex0              (hex0),
        .hex1              (hex1),
        .hex2              (hex2),
        .hex3              (hex3),
        .hex4              (hex4),
        .hex5              (hex5),
        .hex6              (hex6),
        .hex7              (hex7),
        .frame_done        (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // Advance to the next sampling point (falling edge); cyc counts cycles since release.
    task automatic tick();
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic wait_mod(input int m);
        while ((cyc % 30) != m) tick();
    endtask

    task automatic test_reset();
        logic [55:0] exp_hex;
        ship_health       = 4'd15;
        current_highscore = 8'd0;
        alltime_highscore = 8'd0;
        resetn            = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (all_hex !== AllBlank) begin
            n_fail++;
            $display("FAIL reset_hex: got %h required %h", all_hex, AllBlank);
        end
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_frame_done: got %b required 0", frame_done);
        end
        resetn = 1'b0;
        cyc    = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp_hex = AllBlank;
            if (k >= 10) exp_hex[13:0]  = {7'h79, 7'h12};
            if (k >= 20) exp_hex[34:14] = {7'h7F, 7'h7F, 7'h40};
            if (k >= 30) exp_hex[55:35] = {7'h7F, 7'h7F, 7'h40};
            n_checks++;
            if (all_hex !== exp_hex) begin
                n_fail++;
                $display("FAIL startup_hex cycle %0d: got %h required %h", k, all_hex, exp_hex);
            end
            n_checks++;
            if (frame_done !== ((k == 30) || (k == 60))) begin
                n_fail++;
                $display("FAIL startup_frame_done cycle %0d: got %b required %b",
                         k, frame_done, ((k == 30) || (k == 60)));
            end
        end
    endtask

    task automatic test_values(input logic [3:0] h, input logic [7:0] c, input logic [7:0] a,
                               input logic [55:0] exp_hex, input string name);
        ship_health       = h;
        current_highscore = c;
        alltime_highscore = a;
        wait_mod(0);
        repeat (30) tick();
        n_checks++;
        if (all_hex !== exp_hex) begin
            n_fail++;
            $display("FAIL %s_hex: got %h required %h", name, all_hex, exp_hex);
        end
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_frame_done: got %b required 1", name, frame_done);
        end
    endtask

    task automatic test_mid_change();
        logic [55:0] exp_hex;
        ship_health       = 4'd3;
        current_highscore = 8'd42;
        alltime_highscore = 8'd7;
        wait_mod(0);
        repeat (30) tick();
        wait_mod(12);
        current_highscore = 8'd43;
        wait_mod(20);
        exp_hex = {7'h7F, 7'h7F, 7'h78, 7'h7F, 7'h19, 7'h24, 7'h7F, 7'h30};
        n_checks++;
        if (all_hex !== exp_hex) begin
            n_fail++;
            $display("FAIL mid_change_old: got %h required %h", all_hex, exp_hex);
        end
        repeat (30) tick();
        exp_hex = {7'h7F, 7'h7F, 7'h78, 7'h7F, 7'h19, 7'h30, 7'h7F, 7'h30};
        n_checks++;
        if (all_hex !== exp_hex) begin
            n_fail++;
            $display("FAIL mid_change_new: got %h required %h", all_hex, exp_hex);
        end
    endtask

    task automatic test_reset_mid_pass();
        logic [55:0] exp_full;
        exp_full = {7'h7F, 7'h7F, 7'h78, 7'h7F, 7'h19, 7'h30, 7'h7F, 7'h30};
        wait_mod(24);
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (all_hex !== AllBlank) begin
            n_fail++;
            $display("FAIL midreset_hex: got %h required %h", all_hex, AllBlank);
        end
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_frame_done: got %b required 0", frame_done);
        end
        @(negedge clk);
        resetn = 1'b0;
        cyc    = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_checks++;
            if (frame_done !== (k == 30)) begin
                n_fail++;
                $display("FAIL restart_frame_done cycle %0d: got %b required %b",
                         k, frame_done, (k == 30));
            end
            if (k == 9) begin
                n_checks++;
                if (all_hex !== AllBlank) begin
                    n_fail++;
                    $display("FAIL restart_blank: got %h required %h", all_hex, AllBlank);
                end
            end
            if (k == 10) begin
                n_checks++;
                if (all_hex !== {{6{7'h7F}}, 7'h7F, 7'h30}) begin
                    n_fail++;
                    $display("FAIL restart_health: got %h required %h",
                             all_hex, {{6{7'h7F}}, 7'h7F, 7'h30});
                end
            end
            if (k == 30) begin
                n_checks++;
                if (all_hex !== exp_full) begin
                    n_fail++;
                    $display("FAIL restart_full: got %h required %h", all_hex, exp_full);
                end
            end
        end
    endtask

    initial begin
        resetn            = 1'b1;
        ship_health       = 4'd0;
        current_highscore = 8'd0;
        alltime_highscore = 8'd0;
        test_reset();
        test_values(4'd9, 8'd255, 8'd128,
                    {7'h79, 7'h24, 7'h00, 7'h24, 7'h12, 7'h12, 7'h7F, 7'h10}, "vals_9_255_128");
        test_values(4'd9, 8'd100, 8'd7,
                    {7'h7F, 7'h7F, 7'h78, 7'h79, 7'h40, 7'h40, 7'h7F, 7'h10}, "vals_9_100_7");
        test_values(4'd10, 8'd10, 8'd200,
                    {7'h24, 7'h40, 7'h40, 7'h7F, 7'h79, 7'h40, 7'h79, 7'h40}, "vals_10_10_200");
        test_mid_change();
        test_reset_mid_pass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_score_display.md
# hex_score_display

Converts the game's three status values (ship health, current score, all-time high score) from binary to decimal and drives eight active-low seven-segment digits. It sits directly downstream of the health/score tracking stage and consumes its ship_health, current_highscore and alltime_highscore outputs. A round-robin state machine converts one value at a time with a sequential shift-and-add-3 (double-dabble) pass, so no wide combinational divider is needed.

## Interface
- No parameters.
- clk  in  1  system clock (CLOCK_50 at top level)
- resetn  in  1  one clock; reset is synchronous and active-high (resetn=1 resets)
- ship_health  in  4  health value, 0–15
- current_highscore  in  8  current score, 0–255
- alltime_highscore  in  8  all-time score, 0–255
- hex0 … hex7  out  7 each  active-low segments; bit0=a … bit6=g
- frame_done  out  1  one-cycle pulse when a full 3-field refresh completes

## Operation
- Digit mapping:
  - hex1:hex0 = health (tens:units).
  - hex4:hex3:hex2 = current score (hundreds:tens:units).
  - hex7:hex6:hex5 = all-time score (hundreds:tens:units).
- Segment codes, 0–9:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - blank=7'h7F.
- Leading-zero blanking:
  - Units digit is always shown.
  - Tens digit is blanked only if the hundreds and tens digits are both zero.
  - Hundreds digit is blanked if zero.
  - Interior zeros are shown (100 → "1","0","0").
- Field index fidx: 0=health, 1=current, 2=all-time. Wraps 2→0.
- States:
  - LOAD: latch the selected input, zero-extended to 8 bits, into a 20-bit shift register (12-bit BCD, 8-bit binary). Clear the 3-bit shift counter.
  - SHIFT: each cycle, add 3 to each BCD nibble that is ≥5, then shift the whole register left by 1. Exactly 8 cycles.
  - WRITE: encode the BCD nibbles and apply blanking. Register the result into the digit outputs owned by fidx (other digits hold). Advance fidx. Go to LOAD.
- Each field takes 10 cycles (1 LOAD + 8 SHIFT + 1 WRITE). A full frame is 30 cycles and the machine free-runs.
- BCD hundreds nibble never exceeds 2. Health hundreds nibble is always 0 and is discarded.
- Inputs are sampled only in LOAD:
  - An input change during SHIFT or WRITE has no effect on the current pass.
  - The change appears on the next pass for that field.
- Reset:
  - Any cycle with resetn=1 forces: all hexN=7'h7F, frame_done=0, fidx=0, state=LOAD, shift register and counter cleared.
  - Reset mid-conversion aborts the pass. No partial result is ever written.

## Timing
- Cycle 0 is the first cycle after resetn falls to 0. Cycle 0 is LOAD for field 0.
- Health pass: cycles 1–8 SHIFT, cycle 9 WRITE.
- hex1/hex0 carry the new value from cycle 10.
- hex4–hex2 update from cycle 20; hex7–hex5 update from cycle 30.
- Steady state: each digit group refreshes every 30 cycles.
- Worst-case input-to-display latency is 39 cycles (input changes just after its LOAD).
- frame_done:
  - High for exactly one cycle, the same cycle hex7–hex5 first show a new value (cycles 30, 60, 90, …).
  - Low at all other times.
- All outputs are registered. No combinational path exists from any input to any output.

## Test plan
- Reset held 5 cycles, then released: all hexN=7'h7F through cycle 9; frame_done first high at cycle 30, then every 30 cycles.
- health=15, current=0, alltime=0: hex1=7'h79, hex0=7'h12; hex4=hex3=7'h7F, hex2=7'h40; hex7=hex6=7'h7F, hex5=7'h40.
- health=9, current=255, alltime=128: hex1=7'h7F, hex0=7'h10; hex4..2=7'h24,7'h12,7'h12; hex7..5=7'h79,7'h24,7'h00.
- current=100, alltime=7: hex4..2=7'h79,7'h40,7'h40 (interior zeros shown); hex7=hex6=7'h7F, hex5=7'h78.
- Change current 42→43 during field 1 SHIFT: that frame shows 42 (hex3=7'h19, hex2=7'h24); the next frame shows 43 (hex2=7'h30); health/alltime digits are not disturbed.
- Assert resetn during field 2 SHIFT: all digits become 7'h7F the next cycle with no partial write; after release the sequence restarts at field 0 and the first frame_done comes 30 cycles later.
